// File: rtl/registro_leds_display.sv
// CPU-writable LED register and 4-digit hex display register with a multiplexed 7-segment scan.
// Optional DISPLAY_LEADING_ZERO_BLANK_EN: blank leading zero digits above digit 0.
module registro_leds_display #(
  parameter int unsigned REFRESH_DIV = 100_000
) (
  input  logic        clck_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic        sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [15:0] leds_o,
  output logic [3:0]  anodos_o,
  output logic [6:0]  segmentos_o
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digit_t;

  logic [15:0]   led_reg;
  logic [19:0]   disp_reg;
  logic [CW-1:0] cnt;
  digit_t        idx;
  digit_t        idx_next;
  logic [3:0]    nibble;
  logic [3:0]    onehot;
  logic          lit;
  logic          blank;
  logic          unused_bits;

  assign unused_bits = ^data_i[31:20];

  // Active-low gfedcba hex decode.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    idx_next = DIG0;
    nibble   = 4'h0;
    onehot   = 4'b0000;
    blank    = 1'b0;
    case (idx)
      DIG0: begin idx_next = DIG1; nibble = disp_reg[3:0];   onehot = 4'b0001; end
      DIG1: begin idx_next = DIG2; nibble = disp_reg[7:4];   onehot = 4'b0010; end
      DIG2: begin idx_next = DIG3; nibble = disp_reg[11:8];  onehot = 4'b0100; end
      default: begin idx_next = DIG0; nibble = disp_reg[15:12]; onehot = 4'b1000; end
    endcase
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    case (idx)
      DIG1:    blank = (disp_reg[15:4] == 12'h000);
      DIG2:    blank = (disp_reg[15:8] == 8'h00);
      DIG3:    blank = (disp_reg[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
`endif
    lit = ((onehot & disp_reg[19:16]) != 4'b0000) && !blank;
  end

  // Register file, read-back and LED output register.
  always_ff @(posedge clck_i or posedge rst_i) begin
    if (rst_i) begin
      led_reg  <= 16'h0000;
      disp_reg <= 20'h00000;
      leds_o   <= 16'h0000;
      data_o   <= 32'h0000_0000;
    end else begin
      if (we_i && !sel_i) led_reg  <= data_i[15:0];
      if (we_i && sel_i)  disp_reg <= data_i[19:0];
      leds_o <= led_reg;
      data_o <= sel_i ? {12'h000, disp_reg} : {16'h0000, led_reg};
    end
  end

  // Scan state machine: digit index advances once per REFRESH_DIV cycles.
  always_ff @(posedge clck_i or posedge rst_i) begin
    if (rst_i) begin
      cnt         <= '0;
      idx         <= DIG0;
      anodos_o    <= 4'b1111;
      segmentos_o <= 7'h7F;
    end else begin
      if (cnt == CW'(REFRESH_DIV - 1)) begin
        cnt <= '0;
        idx <= idx_next;
      end else begin
        cnt <= cnt + CW'(1);
      end
      anodos_o    <= lit ? ~onehot : 4'b1111;
      segmentos_o <= lit ? hex7(nibble) : 7'h7F;
    end
  end

endmodule

// File: tb/tb_registro_leds_display.sv
// Directed bench for registro_leds_display with REFRESH_DIV = 4.
module tb_registro_leds_display;

  logic        clk;
  logic        rst;
  logic        we;
  logic        sel;
  logic [31:0] din;
  logic [31:0] dout;
  logic [15:0] leds;
  logic [3:0]  an;
  logic [6:0]  seg;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int n      = 0;
  bit found;

  localparam logic [10:0]  DK     = {4'b1111, 7'h7F};
  localparam logic [43:0]  E_1234 = {4'b0111, 7'h79, 4'b1011, 7'h24, 4'b1101, 7'h30, 4'b1110, 7'h19};
  localparam logic [43:0]  E_DARK = {DK, DK, DK, DK};
  localparam logic [43:0]  E_89AB = {DK, 4'b1011, 7'h10, DK, 4'b1110, 7'h03};
  localparam logic [43:0]  E_FFFF = {4'b0111, 7'h0E, 4'b1011, 7'h0E, 4'b1101, 7'h0E, 4'b1110, 7'h0E};

  registro_leds_display #(.REFRESH_DIV(4)) dut (
    .clck_i(clk), .rst_i(rst), .we_i(we), .sel_i(sel), .data_i(din),
    .data_o(dout), .leds_o(leds), .anodos_o(an), .segmentos_o(seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    n++;
    @(negedge clk);
  endtask

  task automatic wr(input logic s, input logic [31:0] d);
    we = 1'b1; sel = s; din = d;
    tick();
    we = 1'b0;
  endtask

  // n edges since reset release: digit k is shown after edges 4k+1 .. 4k+4 of each frame.
  task automatic check_scan(input string tag, input logic [43:0] exp, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      int d;
      d = ((n - 1) / 4) % 4;
      chk(tag, 32'({an, seg}), 32'(exp[d*11 +: 11]));
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; sel = 1'b0; din = 32'h0;
    tick(); tick();
    chk("rst_leds", 32'(leds), 32'h0000);
    chk("rst_data", dout, 32'h0);
    chk("rst_an",   32'(an), 32'hF);
    chk("rst_seg",  32'(seg), 32'h7F);
    rst = 1'b0; n = 0;

    // LED write: visible on leds_o one edge after the write edge
    wr(1'b0, 32'hFFFF_A5C3);
    chk("led_lat0", 32'(leds), 32'h0000);
    chk("led_rb_old", dout, 32'h0);
    tick();
    chk("led_lat1", 32'(leds), 32'hA5C3);
    chk("led_rb", dout, 32'h0000_A5C3);

    // Full display, then mask 0 keeps scan running, then re-enable
    wr(1'b1, 32'h000F_1234);
    tick();
    check_scan("scan_1234", E_1234, 16);
    wr(1'b1, 32'h0000_1234);
    tick();
    check_scan("mask0", E_DARK, 8);
    wr(1'b1, 32'h000F_1234);
    tick();
    check_scan("scan_resume", E_1234, 8);

    wr(1'b1, 32'h0005_89AB);
    tick();
    check_scan("scan_89AB", E_89AB, 16);

    // Rewrite while digit 2 is lit
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      if (((n - 1) % 16) == 8) found = 1'b1;
      else tick();
    end
    chk("wait_dig2", 32'(found), 32'd1);
    wr(1'b1, 32'hFFFF_FFFF);
    chk("rw_old_seg", 32'({an, seg}), 32'({4'b1011, 7'h10}));
    chk("rw_old_rb", dout, 32'h0005_89AB);
    tick();
    chk("rw_new_seg", 32'({an, seg}), 32'({4'b1011, 7'h0E}));
    chk("rw_new_rb", dout, 32'h000F_FFFF);
    check_scan("rw_dwell", E_FFFF, 12);

    // Reset mid-frame takes effect without a clock edge
    #2 rst = 1'b1;
    #1;
    chk("mrst_leds", 32'(leds), 32'h0000);
    chk("mrst_data", dout, 32'h0);
    chk("mrst_an",   32'(an), 32'hF);
    chk("mrst_seg",  32'(seg), 32'h7F);
    tick(); tick();
    rst = 1'b0; n = 0;
    wr(1'b1, 32'h000F_1234);
    chk("post_rst_dark", 32'({an, seg}), 32'(DK));
    chk("post_rst_leds", 32'(leds), 32'h0000);
    tick();
    check_scan("post_rst_scan", E_1234, 16);

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    wr(1'b1, 32'h000F_0042);
    tick();
    check_scan("lzb_0042", {DK, DK, 4'b1101, 7'h19, 4'b1110, 7'h24}, 16);
    wr(1'b1, 32'h000F_0000);
    tick();
    check_scan("lzb_0000", {DK, DK, DK, 4'b1110, 7'h40}, 16);
`else
    wr(1'b1, 32'h000F_0042);
    tick();
    check_scan("nolzb_0042", {4'b0111, 7'h40, 4'b1011, 7'h40, 4'b1101, 7'h19, 4'b1110, 7'h24}, 16);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
